// File: rtl/cmp_max_sequencer.sv
// Steers a burst of operands through an external magnitude comparator against a running maximum.
// Reports the maximum and the index of its first occurrence.
module cmp_max_sequencer #(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [IW:0]   i_len,
  input  logic [M-1:0]  i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [M-1:0]  o_cmp_argA,
  output logic [M-1:0]  o_cmp_argB,
  input  logic          i_cmp_y,
  output logic          o_busy,
  output logic          o_done,
  output logic [M-1:0]  o_max,
  output logic [IW-1:0] o_idx,
  output logic          o_empty
);

  localparam logic [IW:0] LenMax = (IW + 1)'(N);
  localparam logic [IW:0] LenOne = (IW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW:0]   len_q, len_d;
  logic [IW:0]   count_q, count_d;
  logic [M-1:0]  max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          empty_q, empty_d;
  logic          start_ok;

  assign start_ok = (i_len != '0) && (i_len <= LenMax);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    max_d   = max_q;
    idx_d   = idx_q;
    empty_d = empty_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (start_ok) begin
            state_d = StRun;
            len_d   = i_len;
            count_d = '0;
            empty_d = 1'b0;
          end else begin
            state_d = StDone;
            empty_d = 1'b1;
            max_d   = '0;
            idx_d   = '0;
          end
        end
      end
      StRun: begin
        if (i_valid) begin
          // First beat seeds the maximum; strict compare keeps the earlier index on ties.
          if ((count_q == '0) || i_cmp_y) begin
            max_d = i_data;
            idx_d = count_q[IW-1:0];
          end
          count_d = count_q + LenOne;
          if (count_q == (len_q - LenOne)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
      end
      StDone: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_cmp_argA = i_data;
  assign o_cmp_argB = max_q;
  assign o_max      = max_q;
  assign o_idx      = idx_q;
  assign o_empty    = empty_q;

endmodule

// File: tb/tb_cmp_max_sequencer.sv
// Randomized and directed bench for cmp_max_sequencer against a burst-level reference model.
module tb_cmp_max_sequencer;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic [3:0] i_len;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_cmp_argA;
  logic [7:0] o_cmp_argB;
  logic       cmp_y;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_max;
  logic [2:0] o_idx;
  logic       o_empty;

  int n_cmp = 0;
  int n_err = 0;
  int mdl_held = 0;
  logic [7:0] bdata [0:15];

  cmp_max_sequencer #(.M(8), .N(8)) u_dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_cmp_argA (o_cmp_argA),
    .o_cmp_argB (o_cmp_argB),
    .i_cmp_y    (cmp_y),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_max      (o_max),
    .o_idx      (o_idx),
    .o_empty    (o_empty)
  );

  // Behavioural comparator model.
  assign cmp_y = o_cmp_argA > o_cmp_argB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid every cycle, 1: random gaps plus stray starts, 2: valid pattern 1,0,0,1,0,1
  task automatic run_burst(input int len, input int mode);
    int k;
    int cyc;
    int ref_max;
    int ref_idx;
    logic v;
    logic [5:0] pat;
    pat = 6'b101001;
    i_start = 1'b1;
    i_len   = len[3:0];
    i_valid = 1'b0;
    step();
    i_start = 1'b0;
    cyc = 1;
    k = 0;
    while (k < len && cyc < 200) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 2) v = (cyc <= 6) ? pat[cyc-1] : 1'b1;
      else v = ($urandom_range(0, 2) != 0);
      i_valid = v;
      i_data  = v ? bdata[k] : 8'($urandom);
      if (mode == 1 && $urandom_range(0, 4) == 0) begin
        i_start = 1'b1;
        i_len   = 4'($urandom_range(0, 15));
      end
      #1;
      check("ready_run", o_ready, 1);
      check("busy_run", o_busy, 1);
      check("done_run", o_done, 0);
      check("argA", o_cmp_argA, i_data);
      check("argB", o_cmp_argB, mdl_held);
      step();
      i_start = 1'b0;
      cyc++;
      if (v) begin
        if (k == 0 || int'(i_data) > mdl_held) mdl_held = i_data;
        k++;
      end
    end
    i_valid = 1'b0;
    if (k < len) check("timeout_accepts", k, len);
    ref_max = bdata[0];
    ref_idx = 0;
    for (int j = 1; j < len; j++) begin
      if (bdata[j] > ref_max) begin
        ref_max = bdata[j];
        ref_idx = j;
      end
    end
    check("done", o_done, 1);
    check("ready_done", o_ready, 0);
    check("busy_done", o_busy, 1);
    check("max", o_max, ref_max);
    check("idx", o_idx, ref_idx);
    check("empty", o_empty, 0);
    if (mode == 0) check("latency", cyc, len + 1);
    step();
    check("done_pulse", o_done, 0);
    check("busy_idle", o_busy, 0);
    check("max_hold", o_max, ref_max);
    check("idx_hold", o_idx, ref_idx);
  endtask

  task automatic run_empty(input int len);
    i_start = 1'b1;
    i_len   = len[3:0];
    step();
    i_start = 1'b0;
    mdl_held = 0;
    check("e_done", o_done, 1);
    check("e_empty", o_empty, 1);
    check("e_max", o_max, 0);
    check("e_idx", o_idx, 0);
    check("e_ready", o_ready, 0);
    step();
    check("e_done_pulse", o_done, 0);
    check("e_busy_idle", o_busy, 0);
    check("e_empty_hold", o_empty, 1);
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_len = '0;
    i_data = '0;
    i_valid = 1'b0;
    step();
    step();
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_empty", o_empty, 0);
    check("rst_max", o_max, 0);
    check("rst_idx", o_idx, 0);
    i_rst = 1'b0;
    step();

    bdata[0] = 11; bdata[1] = 14; bdata[2] = 9; bdata[3] = 10;
    run_burst(4, 0);
    bdata[0] = 10; bdata[1] = 10; bdata[2] = 7;
    run_burst(3, 0);
    bdata[0] = 3; bdata[1] = 200; bdata[2] = 200;
    run_burst(3, 0);
    bdata[0] = 255;
    run_burst(1, 0);
    for (int j = 0; j < 8; j++) bdata[j] = 8'(j);
    run_burst(8, 0);
    run_empty(0);
    run_empty(9);
    run_empty(15);
    bdata[0] = 40; bdata[1] = 90; bdata[2] = 60;
    run_burst(3, 2);

    // Reset mid-burst discards the partial burst.
    i_start = 1'b1;
    i_len = 4'd4;
    step();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data = 8'd50;
    step();
    i_data = 8'd70;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_valid = 1'b0;
    mdl_held = 0;
    check("mrst_ready", o_ready, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_done", o_done, 0);
    check("mrst_max", o_max, 0);
    check("mrst_idx", o_idx, 0);
    check("mrst_empty", o_empty, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      check("mrst_no_done", o_done, 0);
    end
    bdata[0] = 5; bdata[1] = 6;
    run_burst(2, 0);

    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++)
        bdata[j] = (t % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      run_burst(len, 1);
      if ($urandom_range(0, 5) == 0) run_empty(($urandom_range(0, 1) == 0) ? 0 : 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
